// File: rtl/serial_frame_receiver_if.sv
`default_nettype none
// ============================================================================
//  Module      : serial_frame_receiver_if
//  Description : Bundle of the serial line and the parallel valid/ready port
//                of serial_frame_receiver. The master drives the line and
//                out_ready; the slave (the receiver) drives everything else.
//  Revision    : 1.0  initial release
// ============================================================================
interface serial_frame_receiver_if #(
   parameter int WIDTH = 4
);
   logic             serial_in;
   logic             out_ready;
   logic [WIDTH-1:0] parallel_out;
   logic             out_valid;
   logic             busy;
   logic             frame_error;
   logic             parity_error;
   logic             overrun;

   modport master (
      output serial_in, out_ready,
      input  parallel_out, out_valid, busy, frame_error, parity_error, overrun
   );

   modport slave (
      input  serial_in, out_ready,
      output parallel_out, out_valid, busy, frame_error, parity_error, overrun
   );
endinterface
`default_nettype wire

// File: rtl/serial_frame_receiver.sv
`default_nettype none
// ============================================================================
//  Module      : serial_frame_receiver
//  Description : One-bit-per-clock framed serial receiver (start 0, WIDTH data
//                bits, optional even parity, stop 1) with a valid/ready word
//                output and one-cycle error/overrun pulses.
//                Optional feature macro: PARITY_EN (adds the parity bit).
//  Revision    : 1.0  initial release
// ============================================================================
module serial_frame_receiver #(
   parameter int WIDTH     = 4,
   parameter bit MSB_FIRST = 1'b0
) (
   input wire clk,
   input wire reset,
   serial_frame_receiver_if.slave bus
);
   localparam int CNT_W = (WIDTH > 2) ? $clog2(WIDTH) : 1;

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_DATA   = 3'd1,
`ifdef PARITY_EN
      ST_PARITY = 3'd2,
`endif
      ST_STOP   = 3'd3,
      ST_RESYNC = 3'd4
   } state_t;

   state_t           state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [WIDTH-1:0] shift_q, shift_d;
   logic [WIDTH-1:0] data_q, data_d;
   logic             valid_q, valid_d;
   logic             ferr_q, ferr_d;
   logic             ovr_q, ovr_d;
   logic [WIDTH-1:0] w_shift_next;
   logic             w_par_bad;

`ifdef PARITY_EN
   logic             par_bad_q, par_bad_d;
   logic             perr_q, perr_d;
   assign w_par_bad = par_bad_q;
`else
   assign w_par_bad = 1'b0;
`endif

   // Bit order of the deserializer: the first data bit ends up at bit 0
   // (LSB-first) or at bit WIDTH-1 (MSB-first) after WIDTH shifts.
   generate
      if (MSB_FIRST) begin : g_msb_first
         assign w_shift_next = {shift_q[WIDTH-2:0], bus.serial_in};
      end else begin : g_lsb_first
         assign w_shift_next = {bus.serial_in, shift_q[WIDTH-1:1]};
      end
   endgenerate

   // State and datapath registers; reset discards any partial frame.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q   <= ST_IDLE;
         cnt_q     <= '0;
         shift_q   <= '0;
         data_q    <= '0;
         valid_q   <= 1'b0;
         ferr_q    <= 1'b0;
         ovr_q     <= 1'b0;
`ifdef PARITY_EN
         par_bad_q <= 1'b0;
         perr_q    <= 1'b0;
`endif
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         shift_q   <= shift_d;
         data_q    <= data_d;
         valid_q   <= valid_d;
         ferr_q    <= ferr_d;
         ovr_q     <= ovr_d;
`ifdef PARITY_EN
         par_bad_q <= par_bad_d;
         perr_q    <= perr_d;
`endif
      end
   end

   // Frame sequencing, stop-bit verdict and output handshake.
   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      shift_d   = shift_q;
      data_d    = data_q;
      valid_d   = valid_q & ~bus.out_ready;   // a pending word is consumed on ready
      ferr_d    = 1'b0;
      ovr_d     = 1'b0;
`ifdef PARITY_EN
      par_bad_d = par_bad_q;
      perr_d    = 1'b0;
`endif
      case (state_q)
         ST_IDLE: begin
            if (!bus.serial_in) begin
               state_d = ST_DATA;
               cnt_d   = '0;
`ifdef PARITY_EN
               par_bad_d = 1'b0;
`endif
            end
         end
         ST_DATA: begin
            shift_d = w_shift_next;
            cnt_d   = cnt_q + 1'b1;
            if (cnt_q == CNT_W'(WIDTH - 1)) begin
`ifdef PARITY_EN
               state_d = ST_PARITY;
`else
               state_d = ST_STOP;
`endif
            end
         end
`ifdef PARITY_EN
         ST_PARITY: begin
            // Even parity: data bits plus parity bit must XOR to zero.
            par_bad_d = bus.serial_in ^ (^shift_q);
            state_d   = ST_STOP;
         end
`endif
         ST_STOP: begin
            if (bus.serial_in) begin
               state_d = ST_IDLE;
               if (w_par_bad) begin
`ifdef PARITY_EN
                  perr_d = 1'b1;
`endif
               end else if (!valid_q || bus.out_ready) begin
                  data_d  = shift_q;
                  valid_d = 1'b1;
               end else begin
                  ovr_d = 1'b1;
               end
            end else begin
               // Stop bit low: hold off until the line returns high so a
               // stuck-low line is not taken as a train of start bits.
               state_d = ST_RESYNC;
               ferr_d  = 1'b1;
`ifdef PARITY_EN
               perr_d  = w_par_bad;
`endif
            end
         end
         ST_RESYNC: begin
            if (bus.serial_in) begin
               state_d = ST_IDLE;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   assign bus.parallel_out = data_q;
   assign bus.out_valid    = valid_q;
   assign bus.busy         = (state_q != ST_IDLE);
   assign bus.frame_error  = ferr_q;
   assign bus.overrun      = ovr_q;
`ifdef PARITY_EN
   assign bus.parity_error = perr_q;
`else
   assign bus.parity_error = 1'b0;
`endif

endmodule
`default_nettype wire
